// File: rtl/prng_ctrl_pkg.sv
// Shared definitions for the PRNG key-issue controller: FSM state encoding,
// key width, seed hold length and a saturating counter helper.
package prng_ctrl_pkg;

  localparam int KEY_W         = 128;
  localparam int SEED_HOLD_CYC = 4;
  localparam int CNT_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_WARM    = 3'd2,
    ST_READY   = 3'd3,
    ST_ISSUE   = 3'd4,
    ST_COOL    = 3'd5,
    ST_EXHAUST = 3'd6
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/prng_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot winner chosen combinationally, searching from
// the registered pointer; the pointer moves past the winner on advance.
module rr_arbiter
  import prng_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] winner,
  output logic [PTR_W-1:0]   ptr
);

  logic [PTR_W-1:0]     ptr_reg;
  logic [PTR_W-1:0]     ptr_next;
  logic [PTR_W-1:0]     win_idx;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] win_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   win_rot;

  // Rotate requests so the pointer sits at bit 0, isolate the lowest set bit,
  // then rotate the single winner back into requester positions.
  always_comb begin
    req_dbl = {req, req} >> ptr_reg;
    req_rot = req_dbl[NUM_REQ-1:0];
    win_rot = req_rot & (-req_rot);
    win_dbl = {{NUM_REQ{1'b0}}, win_rot} << ptr_reg;
    winner  = win_dbl[NUM_REQ-1:0] | win_dbl[2*NUM_REQ-1:NUM_REQ];
  end

  // Encode the winner and compute the slot after it (wrapping at NUM_REQ).
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_idx = PTR_W'(i);
    end
    ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + {{(PTR_W-1){1'b0}}, 1'b1};
  end

  // Pointer register: cleared on reset or new seed, advanced on each grant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_reg <= '0;
    end else if (clear) begin
      ptr_reg <= '0;
    end else if (advance && (|req)) begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/prng_ctrl.sv
// PRNG key-issue controller: seeds and warms an external generator, then
// hands out one generator key per grant to NUM_REQ round-robin requesters.
// Build option: PRNG_CTRL_RESEED_EN enables the reseed-required (EXHAUST)
// stop after RESEED_INTERVAL keys; without it issuing is unlimited.
module prng_ctrl
  import prng_ctrl_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int REFRESH_CYC     = 4,
  parameter int RESEED_INTERVAL = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [KEY_W-1:0]   seed_in,
  input  logic               seed_load,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [KEY_W-1:0]   key_out,
  output logic               key_valid,
  output logic               prng_reset,
  output logic               prng_enable,
  output logic [KEY_W-1:0]   prng_seed,
  input  logic [KEY_W-1:0]   prng_key,
  output logic               ready,
  output logic               reseed_req
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] SEED_LAST  = CNT_W'(SEED_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(REFRESH_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(REFRESH_CYC - 2);
  localparam logic [CNT_W-1:0] RESEED_LIM = CNT_W'(RESEED_INTERVAL);

  state_t               state_reg;
  state_t               state_next;
  logic [CNT_W-1:0]     cyc_reg;
  logic [KEY_W-1:0]     seed_reg;
  logic [KEY_W-1:0]     key_reg;
  logic [NUM_REQ-1:0]   gnt_sel_reg;
  logic [CNT_W-1:0]     issue_cnt_reg;
  logic [CNT_W-1:0]     issue_cnt_inc;
  logic [NUM_REQ-1:0]   arb_winner;
  logic [PTR_W-1:0]     arb_ptr;
  logic                 any_req;
  logic                 arb_fire;
  logic                 issue_live;
  logic                 reseed_due;
  logic                 unused_dbg;

  assign any_req       = |req;
  assign issue_cnt_inc = sat_inc(issue_cnt_reg);
  // Arbitration happens exactly when the FSM is about to enter ISSUE.
  assign arb_fire      = (state_next == ST_ISSUE);

`ifdef PRNG_CTRL_RESEED_EN
  localparam bit RESEED_EN = 1'b1;
  assign reseed_due = (issue_cnt_inc >= RESEED_LIM);
  assign unused_dbg = ^arb_ptr;
`else
  localparam bit RESEED_EN = 1'b0;
  assign reseed_due = 1'b0;
  // Issue counter and pointer are debug-only state in this build.
  assign unused_dbg = ^{arb_ptr, issue_cnt_reg, RESEED_LIM};
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .clear   (seed_load),
    .req     (req),
    .advance (arb_fire),
    .winner  (arb_winner),
    .ptr     (arb_ptr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; seed_load overrides everything, including arbitration.
  // The last COOL cycle doubles as an arbitration slot so back-to-back
  // issues are exactly REFRESH_CYC apart.
  always_comb begin
    state_next = state_reg;
    if (seed_load) begin
      state_next = ST_SEED;
    end else begin
      case (state_reg)
        ST_IDLE:    state_next = ST_IDLE;
        ST_SEED:    if (cyc_reg == SEED_LAST) state_next = ST_WARM;
        ST_WARM:    if (cyc_reg == WARM_LAST) state_next = ST_READY;
        ST_READY:   if (any_req) state_next = ST_ISSUE;
        ST_ISSUE:   state_next = reseed_due ? ST_EXHAUST : ST_COOL;
        ST_COOL:    if (cyc_reg == COOL_LAST) state_next = any_req ? ST_ISSUE : ST_READY;
        ST_EXHAUST: state_next = ST_EXHAUST;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // Output decode; a grant is dropped in the same cycle as reset or seed_load.
  always_comb begin
    prng_reset  = 1'b0;
    prng_enable = 1'b0;
    ready       = 1'b0;
    reseed_req  = 1'b0;
    issue_live  = 1'b0;
    case (state_reg)
      ST_IDLE, ST_SEED: prng_reset = 1'b1;
      ST_WARM, ST_COOL: prng_enable = 1'b1;
      ST_READY: begin
        prng_enable = 1'b1;
        ready       = 1'b1;
      end
      ST_ISSUE: begin
        prng_enable = 1'b1;
        issue_live  = reset & ~seed_load;
      end
      ST_EXHAUST: begin
        prng_enable = 1'b1;
        reseed_req  = RESEED_EN;
      end
      default: prng_reset = 1'b1;
    endcase
  end

  // Per-state dwell counter, restarted on every state change or new seed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc_reg <= '0;
    end else if (seed_load || (state_next != state_reg)) begin
      cyc_reg <= '0;
    end else begin
      cyc_reg <= cyc_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Seed latch, captured key/winner at arbitration, and the issue counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seed_reg      <= '0;
      key_reg       <= '0;
      gnt_sel_reg   <= '0;
      issue_cnt_reg <= '0;
    end else begin
      if (seed_load) begin
        seed_reg <= seed_in;
      end
      if (arb_fire) begin
        key_reg     <= prng_key;
        gnt_sel_reg <= arb_winner;
      end
      if (seed_load) begin
        issue_cnt_reg <= '0;
      end else if (state_reg == ST_ISSUE) begin
        issue_cnt_reg <= issue_cnt_inc;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
      assign gnt[gi] = issue_live & gnt_sel_reg[gi];
    end
  endgenerate

  assign key_valid = issue_live;
  assign key_out   = key_reg;
  assign prng_seed = seed_reg;

endmodule

// File: doc/prng_ctrl.md
PRNG_CTRL -- requirements
Module: prng_ctrl

Interface
REQ-001 Param NUM_REQ, default 4, number of key requesters (2..8).
REQ-002 Param REFRESH_CYC, default 4, min cycles between key issues; covers the generator's divide-by-4 output update, so no key is issued twice.
REQ-003 Param RESEED_INTERVAL, default 1024, keys issued per seed before reseed is required.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 seed_in  in  128  seed value, sampled when seed_load=1.
REQ-007 seed_load  in  1  single-cycle pulse; load new seed and restart the generator.
REQ-008 req  in  NUM_REQ  level request per requester, held until granted.
REQ-009 gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
REQ-010 key_out  out  128  issued key, valid with key_valid.
REQ-011 key_valid  out  1  high exactly in the gnt cycle.
REQ-012 prng_reset  out  1  active-high reset to the generator.
REQ-013 prng_enable  out  1  enable to the generator.
REQ-014 prng_seed  out  128  registered seed driven to the generator.
REQ-015 prng_key  in  128  generator key output.
REQ-016 ready  out  1  high in state READY only.
REQ-017 reseed_req  out  1  high in state EXHAUST only.

Function
REQ-018 FSM states: IDLE, SEED, WARM, READY, ISSUE, COOL, EXHAUST.
REQ-019 IDLE: no seed held; outputs idle; seed_load -> SEED.
REQ-020 SEED: prng_reset=1 and prng_enable=0 for 4 cycles, prng_seed = latched seed; then -> WARM.
REQ-021 WARM: prng_reset=0, prng_enable=1 for REFRESH_CYC cycles; then -> READY.
REQ-022 prng_enable stays 1 in WARM, READY, ISSUE, COOL and EXHAUST.
REQ-023 READY: if any req bit is set, pick a winner by round-robin and -> ISSUE; else stay.
REQ-024 Round-robin: the search starts at the index after the last grantee; the pointer is 0 after reset and after each seed_load.
REQ-025 ISSUE: gnt[winner]=1, key_valid=1, key_out = prng_key registered on the READY->ISSUE edge; 1 cycle; then -> COOL.
REQ-026 COOL: REFRESH_CYC-1 cycles with no grant; then -> READY. Issue-to-issue spacing is at least REFRESH_CYC cycles.
REQ-027 A request dropped before its grant is ignored; at most one gnt bit is set per cycle.
REQ-028 key_out holds its last value outside ISSUE; key_valid is 0 there.
REQ-029 A seed_load in any state except SEED does all of the following in that cycle:
  - latches seed_in;
  - suppresses any grant;
  - resets the issue counter;
  - moves to SEED.
REQ-030 A seed_load during SEED re-latches the seed and restarts the 4-cycle count.
REQ-031 If seed_load and a READY arbitration coincide, seed_load wins and no gnt is issued.
REQ-032 Issue counter is 16 bits, increments on each ISSUE, and saturates (no wrap).

Reset
REQ-033 When reset=0 at posedge:
  - state=IDLE;
  - gnt=0, key_valid=0, key_out=0;
  - prng_reset=1, prng_enable=0, prng_seed=0;
  - ready=0, reseed_req=0;
  - RR pointer=0, issue counter=0.
REQ-034 A reset in mid-issue drops the grant that same cycle. The requester must re-request.

Configuration
REQ-035 Macro PRNG_CTRL_RESEED_EN defined:
  - when the issue counter reaches RESEED_INTERVAL at exit from ISSUE, go to EXHAUST, not COOL;
  - EXHAUST asserts reseed_req and grants nothing until seed_load.
REQ-036 Macro PRNG_CTRL_RESEED_EN undefined:
  - EXHAUST is unreachable and reseed_req is tied 0;
  - the issue counter is kept for debug only;
  - issuing is unlimited.

Structure
REQ-037 Shared package prng_ctrl_pkg holds:
  - the state enum;
  - SEED_HOLD_CYC = 4;
  - the key width constant 128.
REQ-038 Round-robin arbiter is one sub-module, rr_arbiter. Inputs: req, advance. Outputs: one-hot winner, registered pointer.
REQ-039 The generator is instantiated outside this block; prng_ctrl only drives its ports.

Verification
REQ-040 Reset, then seed_load with seed_in=128'h1:
  - prng_reset high for 4 cycles;
  - ready rises 4+REFRESH_CYC cycles after the pulse.
REQ-041 req=4'b1111 held: grants are 0001, 0010, 0100, 1000, 0001, spaced exactly 4 cycles apart; every key_out differs from the one before.
REQ-042 req=4'b0100 only, requester drops req after its grant: one grant, then ready stays high with no further gnt.
REQ-043 seed_load in the same cycle READY sees req=4'b0001: no gnt; SEED entered; the first later grant goes to requester 0.
REQ-044 With PRNG_CTRL_RESEED_EN and RESEED_INTERVAL=3:
  - after the 3rd grant, reseed_req=1 and requests are ignored;
  - a seed_load clears reseed_req, and grants resume after warm-up.
REQ-045 reset=0 asserted in an ISSUE cycle: next cycle gnt=0, key_valid=0, key_out=0, state IDLE.
